// File: rtl/img_pkg.sv
// Shared image-buffer defaults and address-width helper.
package img_pkg;

  localparam int unsigned IMG_W_DEF = 512;
  localparam int unsigned IMG_H_DEF = 512;
  localparam int unsigned PIX_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } fb_state_e;

  // Bits needed to address 'depth' locations (at least one bit).
  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth <= 1) ? 1 : 32'($clog2(depth));
  endfunction

endpackage

// File: rtl/img_frame_buf_if.sv
// Pixel write, random read and stream-out signals of the frame buffer.
interface img_frame_buf_if
  import img_pkg::*;
#(
  parameter int unsigned ADDR_SZ = addr_width(IMG_W_DEF * IMG_H_DEF),
  parameter int unsigned PIX_W   = PIX_W_DEF
);
  logic               wr_en;
  logic [ADDR_SZ-1:0] wr_addr;
  logic [PIX_W-1:0]   wr_data;
  logic               rd_en;
  logic [ADDR_SZ-1:0] rd_addr;
  logic [PIX_W-1:0]   rd_data;
  logic               rd_valid;
  logic               start;
  logic               busy;
  logic               done;
  logic               m_valid;
  logic               m_ready;
  logic [PIX_W-1:0]   m_data;
  logic               m_eol;
  logic               m_last;

  modport master (
    output wr_en, wr_addr, wr_data, rd_en, rd_addr, start, m_ready,
    input  rd_data, rd_valid, busy, done, m_valid, m_data, m_eol, m_last
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_en, rd_addr, start, m_ready,
    output rd_data, rd_valid, busy, done, m_valid, m_data, m_eol, m_last
  );
endinterface

// File: rtl/img_fb_mem.sv
// Bare simple dual-port pixel array: one write port, one registered read port.
module img_fb_mem
  import img_pkg::*;
#(
  parameter int unsigned DEPTH   = IMG_W_DEF * IMG_H_DEF,
  parameter int unsigned ADDR_SZ = addr_width(DEPTH),
  parameter int unsigned PIX_W   = PIX_W_DEF
) (
  input  logic               clk,
  input  logic               we,
  input  logic [ADDR_SZ-1:0] waddr,
  input  logic [PIX_W-1:0]   wdata,
  input  logic               re,
  input  logic [ADDR_SZ-1:0] raddr,
  output logic [PIX_W-1:0]   rdata
);
  localparam int unsigned AW = addr_width(DEPTH);

  logic [PIX_W-1:0] mem [DEPTH];

  // Read-first: the read sees the array before this edge's write.
  always_ff @(posedge clk) begin
    if (we) mem[AW'(waddr)] <= wdata;
    if (re) rdata <= mem[AW'(raddr)];
  end
endmodule

// File: rtl/img_frame_buf.sv
// Single-frame grayscale buffer with random read port and raster-scan stream engine.
module img_frame_buf
  import img_pkg::*;
#(
  parameter int unsigned IMG_W   = IMG_W_DEF,
  parameter int unsigned IMG_H   = IMG_H_DEF,
  parameter int unsigned PIX_W   = PIX_W_DEF,
  parameter int unsigned ADDR_SZ = addr_width(IMG_W * IMG_H)
) (
  input logic            clk,
  input logic            rst,
  img_frame_buf_if.slave bus
);
  localparam int unsigned DEPTH = IMG_W * IMG_H;
  localparam int unsigned XW    = addr_width(IMG_W);
  localparam int unsigned YW    = addr_width(IMG_H);

  typedef struct packed {
    logic [PIX_W-1:0] data;
    logic             eol;
    logic             last;
  } beat_t;

  fb_state_e          state_q, state_d;
  logic [XW-1:0]      x_q;
  logic [YW-1:0]      y_q;
  logic [ADDR_SZ-1:0] lin_q;
  logic               busy_q, done_q;
  logic               inflight_q, infl_eol_q, infl_last_q;
  beat_t              fifo_q [2];
  logic               wptr_q, rptr_q;
  logic [1:0]         count_q;
  logic               rd_valid_q, rd_oor_q;
  logic [PIX_W-1:0]   rd_hold_q, rd_data_c;
  logic [PIX_W-1:0]   mem_q;

  logic  start_ok_c, rd_in_range_c, wr_in_range_c;
  logic  fetch_c, fetch_eol_c, fetch_last_c;
  logic  m_valid_c, accept_c, push_c, pop_c, last_accept_c;
  logic  mem_re_c;
  logic [ADDR_SZ-1:0] mem_raddr_c;
  beat_t head_c;

  assign rd_in_range_c = 32'(bus.rd_addr) < DEPTH;
  assign wr_in_range_c = 32'(bus.wr_addr) < DEPTH;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_ok_c) state_d = ST_RUN;
      ST_RUN:   if (fetch_c && fetch_last_c) state_d = ST_DRAIN;
      ST_DRAIN: if (last_accept_c) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Fetch arbitration, output-buffer head and handshake decode
  always_comb begin
    start_ok_c   = 1'b0;
    fetch_c      = 1'b0;
    fetch_eol_c  = (x_q == XW'(IMG_W - 1));
    fetch_last_c = fetch_eol_c && (y_q == YW'(IMG_H - 1));
    head_c       = fifo_q[rptr_q];
    m_valid_c    = (count_q != 2'd0) || inflight_q;
    if (state_q == ST_IDLE) start_ok_c = bus.start && !busy_q;
    // Random reads own the port; a fetch also needs a free slot counting the one in flight.
    if (state_q == ST_RUN)
      fetch_c = !bus.rd_en && ((count_q + {1'b0, inflight_q}) < 2'd2);
    // With the buffer empty, the in-flight pixel is presented straight from the array.
    if ((count_q == 2'd0) && inflight_q)
      head_c = '{data: mem_q, eol: infl_eol_q, last: infl_last_q};
    accept_c      = m_valid_c && bus.m_ready;
    pop_c         = accept_c && (count_q != 2'd0);
    push_c        = inflight_q && !(accept_c && (count_q == 2'd0));
    last_accept_c = accept_c && head_c.last && (state_q == ST_DRAIN);
  end

  assign mem_re_c    = (bus.rd_en && rd_in_range_c) || fetch_c;
  assign mem_raddr_c = bus.rd_en ? bus.rd_addr : lin_q;

  img_fb_mem #(
    .DEPTH  (DEPTH),
    .ADDR_SZ(ADDR_SZ),
    .PIX_W  (PIX_W)
  ) u_mem (
    .clk  (clk),
    .we   (bus.wr_en && wr_in_range_c),
    .waddr(bus.wr_addr),
    .wdata(bus.wr_data),
    .re   (mem_re_c),
    .raddr(mem_raddr_c),
    .rdata(mem_q)
  );

  // Raster position and linear address, stepped together
  always_ff @(posedge clk) begin
    if (rst || start_ok_c) begin
      x_q   <= '0;
      y_q   <= '0;
      lin_q <= '0;
    end else if (fetch_c) begin
      lin_q <= lin_q + ADDR_SZ'(1);
      if (fetch_eol_c) begin
        x_q <= '0;
        y_q <= y_q + YW'(1);
      end else begin
        x_q <= x_q + XW'(1);
      end
    end
  end

  // Fetch pipeline stage and 2-entry output buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q  <= 1'b0;
      infl_eol_q  <= 1'b0;
      infl_last_q <= 1'b0;
      fifo_q[0]   <= '0;
      fifo_q[1]   <= '0;
      wptr_q      <= 1'b0;
      rptr_q      <= 1'b0;
      count_q     <= 2'd0;
    end else begin
      inflight_q  <= fetch_c;
      infl_eol_q  <= fetch_eol_c;
      infl_last_q <= fetch_last_c;
      if (push_c) begin
        fifo_q[wptr_q] <= '{data: mem_q, eol: infl_eol_q, last: infl_last_q};
        wptr_q         <= ~wptr_q;
      end
      if (pop_c) rptr_q <= ~rptr_q;
      case ({push_c, pop_c})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // busy spans start acceptance through the done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= last_accept_c;
      if (start_ok_c)  busy_q <= 1'b1;
      else if (done_q) busy_q <= 1'b0;
    end
  end

  // Random-read response; the held copy keeps rd_data steady across stream fetches
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_oor_q   <= 1'b0;
      rd_hold_q  <= '0;
    end else begin
      rd_valid_q <= bus.rd_en;
      rd_oor_q   <= bus.rd_en && !rd_in_range_c;
      if (rd_valid_q) rd_hold_q <= rd_data_c;
    end
  end

  assign rd_data_c = rd_valid_q ? (rd_oor_q ? '0 : mem_q) : rd_hold_q;

  assign bus.rd_data  = rd_data_c;
  assign bus.rd_valid = rd_valid_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.m_valid  = m_valid_c;
  assign bus.m_data   = head_c.data;
  assign bus.m_eol    = head_c.eol;
  assign bus.m_last   = head_c.last;
endmodule

// File: tb/tb_img_frame_buf.sv
// Directed bench for img_frame_buf on a 4x4 frame.
module tb_img_frame_buf;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  img_frame_buf_if #(.ADDR_SZ(5), .PIX_W(8)) bus ();

  img_frame_buf #(
    .IMG_W  (4),
    .IMG_H  (4),
    .PIX_W  (8),
    .ADDR_SZ(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Stream one frame, optionally with m_ready backpressure and random reads; abort_at>0 stops after that many beats.
  task automatic stream_run(input bit use_bp, input bit use_rd, input int abort_at);
    logic [31:0] bp_pat;
    int          beat;
    bit          fin;
    bit          prev_rd;
    logic [4:0]  prev_addr;
    bit          stalled;
    logic [7:0]  st_data;
    logic        st_eol, st_last;
    bp_pat    = 32'hB4E1_9A35;
    beat      = 0;
    fin       = 1'b0;
    prev_rd   = 1'b0;
    prev_addr = '0;
    stalled   = 1'b0;
    st_data   = '0;
    st_eol    = 1'b0;
    st_last   = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("busy_after_start", bus.busy, 1);
    for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
      chk("rd_valid", bus.rd_valid, prev_rd);
      if (prev_rd) chk("rd_data", bus.rd_data, 32'hA0 + prev_addr);
      if (stalled) begin
        chk("stall_valid", bus.m_valid, 1);
        chk("stall_data", bus.m_data, st_data);
        chk("stall_eol", bus.m_eol, st_eol);
        chk("stall_last", bus.m_last, st_last);
      end
      if (bus.done) begin
        fin = 1'b1;
        chk("beats", beat, 16);
        chk("busy_at_done", bus.busy, 1);
        bus.rd_en = 1'b0;
        tick();
        chk("busy_after_done", bus.busy, 0);
        chk("done_pulse", bus.done, 0);
      end else begin
        bus.m_ready = use_bp ? bp_pat[cyc % 32] : 1'b1;
        bus.rd_en   = use_rd && cyc[0];
        bus.rd_addr = 5'(cyc % 16);
        prev_rd     = bus.rd_en;
        prev_addr   = bus.rd_addr;
        stalled     = bus.m_valid && !bus.m_ready;
        st_data     = bus.m_data;
        st_eol      = bus.m_eol;
        st_last     = bus.m_last;
        if (bus.m_valid && bus.m_ready) begin
          chk("beat_data", bus.m_data, 32'hA0 + beat);
          chk("beat_eol", bus.m_eol, (beat % 4) == 3);
          chk("beat_last", bus.m_last, beat == 15);
          beat++;
          if (beat == abort_at) begin
            fin       = 1'b1;
            bus.rd_en = 1'b0;
          end
        end
        tick();
      end
    end
    chk("stream_finished", fin, 1);
    bus.rd_en   = 1'b0;
    bus.m_ready = 1'b1;
  endtask

  initial begin
    n_cmp       = 0;
    n_err       = 0;
    rst         = 1'b1;
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.rd_en   = 1'b0;
    bus.rd_addr = '0;
    bus.start   = 1'b0;
    bus.m_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_rd_valid", bus.rd_valid, 0);
    chk("rst_rd_data", bus.rd_data, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_m_data", bus.m_data, 0);
    chk("rst_m_eol", bus.m_eol, 0);
    chk("rst_m_last", bus.m_last, 0);

    // Load the frame; an out-of-range write must be dropped
    for (int k = 0; k < 16; k++) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = 5'(k);
      bus.wr_data = 8'(8'hA0 + k);
      tick();
    end
    bus.wr_addr = 5'd16;
    bus.wr_data = 8'hFF;
    tick();
    bus.wr_en = 1'b0;

    bus.rd_en   = 1'b1;
    bus.rd_addr = 5'd5;
    tick();
    bus.rd_en = 1'b0;
    chk("rd5_valid", bus.rd_valid, 1);
    chk("rd5_data", bus.rd_data, 8'hA5);
    tick();
    chk("rd_idle_valid", bus.rd_valid, 0);
    chk("rd_hold_data", bus.rd_data, 8'hA5);
    bus.rd_en   = 1'b1;
    bus.rd_addr = 5'd16;
    tick();
    chk("rd16_valid", bus.rd_valid, 1);
    chk("rd16_data", bus.rd_data, 0);
    bus.rd_addr = 5'd0;
    tick();
    chk("rd0_data", bus.rd_data, 8'hA0);

    // Same-cycle write and read of addr 3
    bus.wr_en   = 1'b1;
    bus.wr_addr = 5'd3;
    bus.wr_data = 8'h55;
    bus.rd_addr = 5'd3;
    tick();
    bus.wr_en = 1'b0;
    chk("coll_old", bus.rd_data, 8'hA3);
    tick();
    bus.rd_en = 1'b0;
    chk("coll_new", bus.rd_data, 8'h55);
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'hA3;
    tick();
    bus.wr_en = 1'b0;

    // Full stream, exact cycle timing
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("s0_busy", bus.busy, 1);
    chk("s0_m_valid", bus.m_valid, 0);
    tick();
    for (int b = 0; b < 16; b++) begin
      chk("s_valid", bus.m_valid, 1);
      chk("s_data", bus.m_data, 32'hA0 + b);
      chk("s_eol", bus.m_eol, (b % 4) == 3);
      chk("s_last", bus.m_last, b == 15);
      chk("s_done_low", bus.done, 0);
      tick();
    end
    chk("s_done", bus.done, 1);
    chk("s_busy_done", bus.busy, 1);
    chk("s_valid_end", bus.m_valid, 0);
    tick();
    chk("s_done_end", bus.done, 0);
    chk("s_busy_end", bus.busy, 0);

    stream_run(1'b1, 1'b0, 0);
    stream_run(1'b0, 1'b1, 0);

    // Reset after beat 6, then restream from the start
    stream_run(1'b0, 1'b0, 7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_m_valid", bus.m_valid, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_m_data", bus.m_data, 0);
    chk("mid_rst_done", bus.done, 0);
    tick();
    chk("mid_rst_idle", bus.m_valid, 0);
    stream_run(1'b1, 1'b1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
